// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring-mode CORDIC: (x, y) -> angle, magnitude
//
// Purpose:
//   Rotates the input vector onto the +x axis one micro-rotation per cycle,
//   accumulating the applied angle in z. The final x is the magnitude, which
//   carries the raw CORDIC gain unless gain compensation is compiled in.
//
// Build option:
//   CORDIC_VEC_GAIN_COMP_EN - when defined, adds a SCALE state that multiplies
//   the final x by GAIN (1/K). Latency grows from LENGTH+1 to LENGTH+2.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   request, sampled only in IDLE
//   x_in       in  16   signed Q2.14 x, must be >= 0
//   y_in       in  16   signed Q2.14 y
//   busy       out  1   computation in progress
//   done       out  1   one-cycle pulse when results update
//   angle      out 16   signed Q2.14 radians
//   mag        out 18   signed Q4.14 magnitude
//   range_err  out  1   last accepted request had x_in < 0

module cordic_vectoring #(
    parameter int LENGTH    = 8,
    parameter int FRAC_BITS = 14,
    parameter logic signed [FRAC_BITS+1:0] ATAN_LUT [16] = '{
        16'sd12868, 16'sd7596, 16'sd4014, 16'sd2037,
        16'sd1023,  16'sd512,  16'sd256,  16'sd128,
        16'sd64,    16'sd32,   16'sd16,   16'sd8,
        16'sd4,     16'sd2,    16'sd1,    16'sd0
    },
    parameter int GAIN      = 9949
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAC_BITS+1:0]  x_in,
    input  logic [FRAC_BITS+1:0]  y_in,
    output logic                  busy,
    output logic                  done,
    output logic [FRAC_BITS+1:0]  angle,
    output logic [FRAC_BITS+3:0]  mag,
    output logic                  range_err
);

    // AW: Q2.14 angle/input width. W: Q4.14 working width for x and y.
    localparam int AW = FRAC_BITS + 2;
    localparam int W  = FRAC_BITS + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_SCALE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic signed [W-1:0]   x_q, x_d;
    logic signed [W-1:0]   y_q, y_d;
    logic signed [AW-1:0]  z_q, z_d;
    logic [3:0]            iter_q, iter_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic [AW-1:0]         angle_q, angle_d;
    logic [W-1:0]          mag_q, mag_d;
    logic                  range_err_q, range_err_d;

    logic signed [W-1:0]   x_sh;
    logic signed [W-1:0]   y_sh;

    assign x_sh = x_q >>> iter_q;
    assign y_sh = y_q >>> iter_q;

`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam logic signed [W-1:0] GAIN_S = (W)'(GAIN);

    logic signed [2*W-1:0] prod;
    logic signed [W-1:0]   x_scaled;

    // Arithmetic shift then truncate keeps bits [31:14]: rounds toward -inf.
    assign prod     = x_q * GAIN_S;
    assign x_scaled = (W)'(prod >>> FRAC_BITS);
`else
    // GAIN only feeds the compensated build; keep it referenced as a sanity guard.
    if (GAIN <= 0) begin : g_gain_not_positive
    end
`endif

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        iter_d      = iter_q;
        err_d       = err_q;
        done_d      = 1'b0;
        angle_d     = angle_q;
        mag_d       = mag_q;
        range_err_d = range_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = {{(W-AW){x_in[AW-1]}}, x_in};
                    y_d     = {{(W-AW){y_in[AW-1]}}, y_in};
                    z_d     = '0;
                    iter_d  = 4'd0;
                    err_d   = x_in[AW-1];
                    state_d = S_ITER;
                end
            end

            S_ITER: begin
                // Drive y toward zero; y == 0 takes the non-negative branch.
                if (!y_q[W-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + ATAN_LUT[iter_q];
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - ATAN_LUT[iter_q];
                end
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'(LENGTH - 1)) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                    state_d = S_SCALE;
`else
                    state_d = S_DONE;
`endif
                end
            end

`ifdef CORDIC_VEC_GAIN_COMP_EN
            S_SCALE: begin
                x_d     = x_scaled;
                state_d = S_DONE;
            end
`endif

            S_DONE: begin
                done_d      = 1'b1;
                range_err_d = err_q;
                angle_d     = err_q ? '0 : z_q;
                mag_d       = err_q ? '0 : x_q;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            iter_q      <= 4'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            angle_q     <= '0;
            mag_q       <= '0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            iter_q      <= iter_d;
            err_q       <= err_d;
            done_q      <= done_d;
            angle_q     <= angle_d;
            mag_q       <= mag_d;
            range_err_q <= range_err_d;
        end
    end

    // Busy covers ITER, SCALE and DONE; it drops on the same edge done rises.
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign angle     = angle_q;
    assign mag       = mag_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - directed self-checking bench for cordic_vectoring

module tb_cordic_vectoring;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic        busy;
    logic        done;
    logic [15:0] angle;
    logic [17:0] mag;
    logic        range_err;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  N       = 10;
    localparam real G       = 1.0;
    localparam int  MAG_TOL = 819;
`else
    localparam int  N       = 9;
    localparam real G       = 1.64676;
    localparam int  MAG_TOL = 1350;
`endif
    localparam int ANG_TOL = 819;

    cordic_vectoring dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .angle     (angle),
        .mag       (mag),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ang_s();
        return int'($signed(angle));
    endfunction

    function automatic int mag_s();
        return int'($signed(mag));
    endfunction

    // Issues one request and returns the edge count from accept to done (-1 on timeout).
    task automatic do_op(input int xv, input int yv, output int lat);
        @(negedge clk);
        x_in  = 16'(xv);
        y_in  = 16'(yv);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 4 * N; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0 || done !== 1'b0 || range_err !== 1'b0 ||
                angle !== 16'd0 || mag !== 18'd0) begin
                tests_failed++;
                $display("FAIL reset_idle cycle %0d: busy=%b done=%b err=%b angle=%0d mag=%0d required all 0",
                         c, busy, done, range_err, angle, mag);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        int em;
        em = int'(11585.0 * G);
        do_op(8192, 8192, lat);
        tests_run++;
        if (lat !== N) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d required %0d", lat, N);
        end
        tests_run++;
        if (iabs(ang_s() - 12868) > ANG_TOL) begin
            tests_failed++;
            $display("FAIL basic_angle: got %0d required 12868+-%0d", ang_s(), ANG_TOL);
        end
        tests_run++;
        if (iabs(mag_s() - em) > MAG_TOL) begin
            tests_failed++;
            $display("FAIL basic_mag: got %0d required %0d+-%0d", mag_s(), em, MAG_TOL);
        end
        tests_run++;
        if (range_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_flags: range_err=%b busy=%b required 0 0", range_err, busy);
        end
    endtask

    task automatic test_sweep();
        int  lat;
        int  xv;
        int  yv;
        int  ea;
        int  em;
        real th;
        em = int'(16384.0 * G);
        for (int k = -15; k <= 15; k++) begin
            th = k * 0.1;
            xv = int'($cos(th) * 16384.0);
            yv = int'($sin(th) * 16384.0);
            ea = int'(th * 16384.0);
            do_op(xv, yv, lat);
            tests_run++;
            if (lat !== N || iabs(ang_s() - ea) > ANG_TOL || iabs(mag_s() - em) > MAG_TOL) begin
                tests_failed++;
                $display("FAIL sweep k=%0d: lat=%0d angle=%0d mag=%0d required lat=%0d angle=%0d mag=%0d",
                         k, lat, ang_s(), mag_s(), N, ea, em);
            end
        end
    endtask

    task automatic test_range_err();
        int lat;
        int em;
        do_op(-4096, 100, lat);
        tests_run++;
        if (lat !== N) begin
            tests_failed++;
            $display("FAIL range_latency: got %0d required %0d", lat, N);
        end
        tests_run++;
        if (angle !== 16'd0 || mag !== 18'd0 || range_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL range_outputs: angle=%0d mag=%0d err=%b required 0 0 1", angle, mag, range_err);
        end
        em = int'(8192.0 * G);
        do_op(8192, 0, lat);
        tests_run++;
        if (range_err !== 1'b0 || iabs(ang_s()) > ANG_TOL || iabs(mag_s() - em) > MAG_TOL) begin
            tests_failed++;
            $display("FAIL range_clear: err=%b angle=%0d mag=%0d required 0 0 %0d", range_err, ang_s(), mag_s(), em);
        end
    endtask

    task automatic test_start_held();
        int ndone;
        int lat;
        int em;
        em = int'(16384.0 * G);
        @(negedge clk);
        x_in  = 16'd16384;
        y_in  = 16'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        x_in  = 16'd0;
        y_in  = 16'd16384;
        ndone = 0;
        lat   = -1;
        for (int c = 1; c <= 2 * N + 2; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) lat = c;
                start = 1'b0;
            end
        end
        start = 1'b0;
        tests_run++;
        if (ndone !== 1 || lat !== N) begin
            tests_failed++;
            $display("FAIL held_done: count=%0d first=%0d required 1 at %0d", ndone, lat, N);
        end
        tests_run++;
        if (iabs(ang_s()) > ANG_TOL || iabs(mag_s() - em) > MAG_TOL) begin
            tests_failed++;
            $display("FAIL held_result: angle=%0d mag=%0d required 0 %0d", ang_s(), mag_s(), em);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int first;
        int last;
        @(negedge clk);
        x_in  = 16'd8192;
        y_in  = 16'd8192;
        start = 1'b1;
        @(posedge clk);
        ndone = 0;
        first = -1;
        last  = -1;
        for (int e = 1; e <= 3 * N + 2; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first < 0) first = e;
                last = e;
            end
        end
        start = 1'b0;
        tests_run++;
        if (ndone !== 3 || first !== N || last !== 3 * N + 2) begin
            tests_failed++;
            $display("FAIL b2b_spacing: count=%0d first=%0d last=%0d required 3 %0d %0d",
                     ndone, first, last, N, 3 * N + 2);
        end
        tests_run++;
        if (iabs(ang_s() - 12868) > ANG_TOL) begin
            tests_failed++;
            $display("FAIL b2b_angle: got %0d required 12868", ang_s());
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        int lat;
        int em;
        @(negedge clk);
        x_in  = 16'd8192;
        y_in  = 16'(-8192);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || range_err !== 1'b0 ||
            angle !== 16'd0 || mag !== 18'd0) begin
            tests_failed++;
            $display("FAIL midreset_async: busy=%b done=%b err=%b angle=%0d mag=%0d required all 0",
                     busy, done, range_err, angle, mag);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < N + 3; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        tests_run++;
        if (ndone !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_done: got %0d pulses required 0", ndone);
        end
        em = int'(11585.0 * G);
        do_op(8192, -8192, lat);
        tests_run++;
        if (lat !== N || iabs(ang_s() + 12868) > ANG_TOL || iabs(mag_s() - em) > MAG_TOL) begin
            tests_failed++;
            $display("FAIL midreset_recover: lat=%0d angle=%0d mag=%0d required %0d -12868 %0d",
                     lat, ang_s(), mag_s(), N, em);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_range_err();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative vectoring-mode CORDIC: takes a Cartesian point (x, y) and returns its angle atan(y/x) and magnitude sqrt(x²+y²) in Q2.14 fixed point. It is the inverse of the rotation-mode sin/cos CORDIC blocks and shares their `ATAN_LUT`/`GAIN` parameter scheme. Use it to recover phase and amplitude from I/Q-style samples produced by, or fed to, the rotation cores. It uses a start/busy handshake like the iterative rotation core, plus a one-cycle `done` pulse.

## Interface
- `LENGTH`, 8: number of CORDIC iterations (1..14).
- `FRAC_BITS`, 14: fraction bits of all fixed-point values.
- `ATAN_LUT`, atan(2^-i)·2^14 for i=0..7: signed 16-bit per-iteration angle table, indexed 0..LENGTH-1.
- `GAIN`, 9949 (0.6072533·2^14): reciprocal CORDIC gain, used only with gain compensation.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `x_in`  in  16: signed Q2.14 x coordinate; must be ≥ 0.
- `y_in`  in  16: signed Q2.14 y coordinate.
- `busy`  out  1: high while a computation is in progress.
- `done`  out  1: one-cycle pulse when results are updated.
- `angle`  out  16: signed Q2.14 radians, in [-π/2, π/2].
- `mag`  out  18: signed Q4.14 magnitude.
- `range_err`  out  1: last accepted request had x_in < 0.

## Operation
- States: IDLE, ITER, SCALE (only when gain compensation is compiled in), DONE.
- IDLE, start=1: latch x_in and y_in into 18-bit sign-extended registers x and y, set z=0 and iteration counter i=0, then go to ITER. If x_in < 0, also latch an internal error flag. `start` is ignored in every other state.
- ITER, one iteration per cycle:
  - If y ≥ 0: x += y>>>i; y −= x>>>i; z += ATAN_LUT[i].
  - Otherwise: x −= y>>>i; y += x>>>i; z −= ATAN_LUT[i].
  - The right-hand sides use the old values of x and y. Shifts are arithmetic. y == 0 takes the y ≥ 0 branch.
- After iteration i = LENGTH−1, go to SCALE if it is compiled in, otherwise to DONE.
- SCALE: compute the 36-bit product x·GAIN and keep bits [31:14], with truncation toward −∞.
- DONE, one cycle:
  - Register `angle`=z and `mag`=the x result.
  - Set `range_err` to the error flag. If the flag is set, force `angle`=0 and `mag`=0.
  - Pulse `done`, then return to IDLE.
- Outputs hold their values until the next DONE.
- Internal width is 18 bits, so there is no overflow for |x|,|y| < 2: the worst-case unscaled magnitude is 2·√2·1.647 ≈ 4.66 < 8.

## Timing
- Reset values: `busy`=0, `done`=0, `angle`=0, `mag`=0, `range_err`=0. State is IDLE.
- Cycle 0 is the edge that samples start=1. From that edge, `busy`=1.
- `done`=1 and `busy`=0 after the edge at cycle N:
  - N = LENGTH+1 without gain compensation.
  - N = LENGTH+2 with gain compensation.
- The outputs become valid on that same edge.
- Back-to-back operation: start may be held high. The next request is accepted on the edge after `done`, in IDLE, so throughput is one result per N+1 cycles.
- Reset asserted mid-operation: immediately abort, return all outputs to their reset values and the state to IDLE. There is no `done` pulse for the aborted request.
- start asserted in the same cycle as `done`: ignored, because the state is DONE and not IDLE.

## Configuration
- `CORDIC_VEC_GAIN_COMP_EN` defined: the SCALE state exists. `mag` ≈ true magnitude, and latency is LENGTH+2.
- `CORDIC_VEC_GAIN_COMP_EN` undefined: SCALE is skipped and the `GAIN` parameter is unused. `mag` = true magnitude × ~1.6468 (raw CORDIC gain), and latency is LENGTH+1.
- `angle` behaves identically in both builds.

## Test plan
Tolerances: angle ±819 (0.05 rad); mag ±819 (comp) / ±1350 (raw).
- Reset with no start: all outputs read 0 and `busy`=0 for 20 cycles.
- x=8192, y=8192 (0.5, 0.5) -> `done` exactly LENGTH+1 (raw) or LENGTH+2 (comp) cycles after start. `angle` ≈ 12868 (π/4). `mag` ≈ 11585 (comp) or ≈ 19078 (raw). `range_err`=0.
- Sweep θ = −1.5..1.5 step 0.1 with x=round(cos θ·2^14), y=round(sin θ·2^14) -> `angle` within tolerance of θ·2^14, and `mag` within tolerance of 16384 (comp) or 26981 (raw).
- x=−4096, y=100 -> `done` at the normal latency, `angle`=0, `mag`=0, `range_err`=1. A following valid request clears `range_err`.
- Start pulsed every cycle while `busy` -> only the first request is processed. Results match the first operands, and exactly one `done` pulse occurs per N+1 cycles.
- rst_n dropped at cycle 3 of an operation -> outputs return to 0 asynchronously with no `done` pulse. A new request after release completes correctly.
